// File: rtl/lib_switch_allocator_rr_pkg.sv
// Shared types, default sizes and helpers for the round-robin switch allocator.
package lib_switch_allocator_rr_pkg;

    typedef enum logic {ALLOC_IDLE, ALLOC_LOCKED} alloc_state_e;

    localparam int ALLOC_N_DEF = 5;
    localparam int ALLOC_M_DEF = 5;

    // Ceiling log2, never below 1 so a pointer always has at least one bit.
    function automatic int log2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/lib_arbiter_rr.sv
// N-way round-robin arbiter: search starts at the pointer, pointer moves past the winner on advance.
module lib_arbiter_rr
    import lib_switch_allocator_rr_pkg::*;
#(
    parameter int N  = ALLOC_N_DEF,
    parameter int PW = log2(ALLOC_N_DEF)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [0:N-1]  req,
    input  logic          advance,
    output logic [0:N-1]  gnt,
    output logic [PW-1:0] win,
    output logic          any
);

    logic [PW-1:0] ptr_q;
    logic [PW-1:0] ptr_d;

    always_comb begin
        int idx;
        gnt = '0;
        win = '0;
        any = 1'b0;
        idx = 0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(ptr_q) + k) % N;
            if (!any && req[idx]) begin
                any      = 1'b1;
                gnt[idx] = 1'b1;
                win      = PW'(idx);
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (advance) begin
            ptr_d = (win == PW'(N - 1)) ? '0 : win + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/lib_switch_allocator_rr.sv
// NxM switch allocator: per-output round-robin with wormhole locking, zero-cycle grant path.
module lib_switch_allocator_rr
    import lib_switch_allocator_rr_pkg::*;
#(
    parameter int N = ALLOC_N_DEF,
    parameter int M = ALLOC_M_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 ce,
    input  logic [0:N-1][0:M-1]  i_req,
    input  logic [0:N-1]         i_tail,
    input  logic [0:M-1]         i_en,
    output logic [0:M-1][0:N-1]  o_sel,
    output logic [0:N-1]         o_grant,
    output logic [0:M-1]         o_valid
);

    localparam int PW = log2(N);

    logic [0:N-1][0:M-1] req_f;
    logic [0:N-1]        busy;
    logic [0:M-1]        locked_vec;
    logic [M-1:0][PW-1:0] owner_vec;

    // A malformed row keeps only its lowest-index request.
    always_comb begin
        logic seen;
        req_f = '0;
        for (int j = 0; j < N; j++) begin
            seen = 1'b0;
            for (int m = 0; m < M; m++) begin
                req_f[j][m] = i_req[j][m] & ~seen;
                seen        = seen | i_req[j][m];
            end
        end
    end

    // An input that owns a locked output may not win any other output.
    always_comb begin
        busy = '0;
        for (int m = 0; m < M; m++) begin
            for (int j = 0; j < N; j++) begin
                if (locked_vec[m] && owner_vec[m] == PW'(j)) busy[j] = 1'b1;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < M; gi++) begin : g_out
            alloc_state_e  st_q;
            alloc_state_e  st_d;
            logic [PW-1:0] owner_q;
            logic [PW-1:0] owner_d;
            logic [0:N-1]  col;
            logic [0:N-1]  arb_gnt;
            logic [PW-1:0] arb_win;
            logic          arb_any;
            logic          advance;
            logic [0:N-1]  sel_m;

            always_comb begin
                for (int j = 0; j < N; j++) col[j] = req_f[j][gi] & ~busy[j];
            end

            lib_arbiter_rr #(
                .N  (N),
                .PW (PW)
            ) u_arb (
                .clk     (clk),
                .reset   (reset),
                .req     (col),
                .advance (advance),
                .gnt     (arb_gnt),
                .win     (arb_win),
                .any     (arb_any)
            );

            always_comb begin
                st_d    = st_q;
                owner_d = owner_q;
                sel_m   = '0;
                advance = 1'b0;
                if (!reset && ce && i_en[gi]) begin
                    case (st_q)
                        ALLOC_IDLE: begin
                            if (arb_any) begin
                                sel_m   = arb_gnt;
                                advance = 1'b1;
                                if (!i_tail[arb_win]) begin
                                    st_d    = ALLOC_LOCKED;
                                    owner_d = arb_win;
                                end
                            end
                        end
                        ALLOC_LOCKED: begin
                            if (req_f[owner_q][gi]) begin
                                sel_m[owner_q] = 1'b1;
                                if (i_tail[owner_q]) st_d = ALLOC_IDLE;
                            end
                        end
                        default: st_d = ALLOC_IDLE;
                    endcase
                end
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    st_q    <= ALLOC_IDLE;
                    owner_q <= '0;
                end else begin
                    st_q    <= st_d;
                    owner_q <= owner_d;
                end
            end

            assign locked_vec[gi] = (st_q == ALLOC_LOCKED);
            assign owner_vec[gi]  = owner_q;
            assign o_sel[gi]      = sel_m;
            assign o_valid[gi]    = |sel_m;
        end
    endgenerate

    always_comb begin
        o_grant = '0;
        for (int j = 0; j < N; j++) begin
            for (int m = 0; m < M; m++) o_grant[j] = o_grant[j] | o_sel[m][j];
        end
    end

endmodule

// File: tb/tb_lib_switch_allocator_rr.sv
// Directed vector bench for the 5x5 round-robin switch allocator.
module tb_lib_switch_allocator_rr;

    localparam int N = 5;
    localparam int M = 5;

    typedef logic [0:N-1][0:M-1] req_t;
    typedef logic [0:M-1][0:N-1] sel_t;

    typedef struct {
        string      name;
        req_t       req;
        logic [0:N-1] tail;
        logic [0:M-1] en;
        logic       ce;
        logic       rst;
        sel_t       sel;
        logic [0:N-1] gnt;
    } vec_t;

    logic                clk = 1'b0;
    logic                reset;
    logic                ce;
    logic [0:N-1][0:M-1] i_req;
    logic [0:N-1]        i_tail;
    logic [0:M-1]        i_en;
    logic [0:M-1][0:N-1] o_sel;
    logic [0:N-1]        o_grant;
    logic [0:M-1]        o_valid;

    int checks = 0;
    int passed = 0;

    lib_switch_allocator_rr #(.N(N), .M(M)) dut (
        .clk     (clk),
        .reset   (reset),
        .ce      (ce),
        .i_req   (i_req),
        .i_tail  (i_tail),
        .i_en    (i_en),
        .o_sel   (o_sel),
        .o_grant (o_grant),
        .o_valid (o_valid)
    );

    always #5 clk = ~clk;

    function automatic req_t rq(input int j, input int m);
        req_t r;
        r = '0;
        r[j][m] = 1'b1;
        return r;
    endfunction

    function automatic sel_t sl(input int m, input int j);
        sel_t s;
        s = '0;
        s[m][j] = 1'b1;
        return s;
    endfunction

    function automatic logic [0:N-1] oh(input int j);
        logic [0:N-1] v;
        v = '0;
        v[j] = 1'b1;
        return v;
    endfunction

    function automatic vec_t mk(input string name, input req_t req, input logic [0:N-1] tail,
                                input logic [0:M-1] en, input logic c, input logic r,
                                input sel_t sel, input logic [0:N-1] gnt);
        vec_t v;
        v.name = name; v.req = req; v.tail = tail; v.en = en;
        v.ce = c; v.rst = r; v.sel = sel; v.gnt = gnt;
        return v;
    endfunction

    task automatic run(input vec_t v);
        logic [0:M-1] exp_valid;
        logic [0:N-1] or_sel;
        logic         ok;
        @(negedge clk);
        reset  = v.rst;
        ce     = v.ce;
        i_req  = v.req;
        i_tail = v.tail;
        i_en   = v.en;
        #1;
        ok = 1'b1;
        for (int m = 0; m < M; m++) exp_valid[m] = |v.sel[m];
        or_sel = '0;
        for (int m = 0; m < M; m++) or_sel = or_sel | o_sel[m];
        checks++;
        if (o_sel === v.sel) passed++;
        else begin ok = 1'b0; $display("FAIL %s o_sel: got %h want %h", v.name, o_sel, v.sel); end
        checks++;
        if (o_grant === v.gnt) passed++;
        else begin ok = 1'b0; $display("FAIL %s o_grant: got %b want %b", v.name, o_grant, v.gnt); end
        checks++;
        if (o_valid === exp_valid) passed++;
        else begin ok = 1'b0; $display("FAIL %s o_valid: got %b want %b", v.name, o_valid, exp_valid); end
        checks++;
        if (o_grant === or_sel) passed++;
        else begin ok = 1'b0; $display("FAIL %s grant_vs_sel: grant %b sel_or %b", v.name, o_grant, or_sel); end
        $display("%-12s req=%h tail=%b en=%b ce=%b rst=%b -> sel=%h grant=%b %s",
                 v.name, v.req, v.tail, v.en, v.ce, v.rst, o_sel, o_grant, ok ? "ok" : "bad");
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[$];
        req_t all_req;
        req_t r;
        sel_t s;
        logic [0:N-1] ones;
        logic [0:M-1] en_all;

        all_req = '1;
        ones    = '1;
        en_all  = '1;
        reset = 1'b1; ce = 1'b1; i_req = '0; i_tail = '1; i_en = '1;

        // Reset with all requests high, then first arbitration on output 0.
        vecs.push_back(mk("rst0", all_req, ones, en_all, 1'b1, 1'b1, '0, '0));
        vecs.push_back(mk("rst1", all_req, ones, en_all, 1'b1, 1'b1, '0, '0));
        vecs.push_back(mk("first", all_req, ones, en_all, 1'b1, 1'b0, sl(0, 0), oh(0)));
        // Inputs 0,2,4 share output 1.
        r = rq(0, 1) | rq(2, 1) | rq(4, 1);
        vecs.push_back(mk("rr0", r, ones, en_all, 1'b1, 1'b0, sl(1, 0), oh(0)));
        vecs.push_back(mk("rr1", r, ones, en_all, 1'b1, 1'b0, sl(1, 2), oh(2)));
        vecs.push_back(mk("rr2", r, ones, en_all, 1'b1, 1'b0, sl(1, 4), oh(4)));
        vecs.push_back(mk("rr3", r, ones, en_all, 1'b1, 1'b0, sl(1, 0), oh(0)));
        vecs.push_back(mk("rr4", r, ones, en_all, 1'b1, 1'b0, sl(1, 2), oh(2)));
        // Move output 0 pointer to 3, then a 3-flit packet from input 3 against input 1.
        vecs.push_back(mk("prep", rq(2, 0), ones, en_all, 1'b1, 1'b0, sl(0, 2), oh(2)));
        r = rq(3, 0) | rq(1, 0);
        vecs.push_back(mk("pkt_f1", r, 5'b11101, en_all, 1'b1, 1'b0, sl(0, 3), oh(3)));
        vecs.push_back(mk("pkt_f2", r, 5'b11101, en_all, 1'b1, 1'b0, sl(0, 3), oh(3)));
        vecs.push_back(mk("pkt_f3", r, ones, en_all, 1'b1, 1'b0, sl(0, 3), oh(3)));
        vecs.push_back(mk("pkt_next", rq(1, 0), ones, en_all, 1'b1, 1'b0, sl(0, 1), oh(1)));

        foreach (vecs[i]) run(vecs[i]);

        // Output 2 blocked downstream for 4 cycles, then released.
        for (int c = 0; c < 4; c++)
            run(mk($sformatf("en_hold%0d", c), rq(4, 2), ones, 5'b11011, 1'b1, 1'b0, '0, '0));
        run(mk("en_release", rq(4, 2), ones, en_all, 1'b1, 1'b0, sl(2, 4), oh(4)));

        // Anti-diagonal: every input to a distinct output in one cycle.
        r = '0;
        s = '0;
        for (int j = 0; j < N; j++) begin
            r = r | rq(j, 4 - j);
            s = s | sl(4 - j, j);
        end
        run(mk("all_five", r, ones, en_all, 1'b1, 1'b0, s, ones));

        // Lock output 0 on input 2, freeze, then reset mid-packet.
        run(mk("lock", rq(2, 0), '0, en_all, 1'b1, 1'b0, sl(0, 2), oh(2)));
        run(mk("owner_other", rq(2, 3), '0, en_all, 1'b1, 1'b0, '0, '0));
        for (int c = 0; c < 3; c++)
            run(mk($sformatf("ce_off%0d", c), rq(2, 0), '0, en_all, 1'b0, 1'b0, '0, '0));
        r = rq(1, 0) | rq(2, 0) | rq(3, 0);
        run(mk("rst_lock", r, '0, en_all, 1'b1, 1'b1, '0, '0));
        run(mk("post_rst", r, ones, en_all, 1'b1, 1'b0, sl(0, 1), oh(1)));

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
